// File: rtl/my_mem_arbiter_if.sv
// Bus bundle between my_mem_arbiter and its surroundings: two level-held
// requesters, completion/read-data return, and the my_mem pin set.
// MEM_ARB_PARITY_CHK_EN adds the perr parity-error pulse to the bundle.
interface my_mem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [8:0]  rdata;
  logic        busy;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [8:0]  mem_data_out;
`ifdef MEM_ARB_PARITY_CHK_EN
  logic        perr;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata, busy, mem_write, mem_read, mem_address,
           mem_data_in, perr
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata, busy, mem_write, mem_read, mem_address,
           mem_data_in, perr
  );
`else
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata, busy, mem_write, mem_read, mem_address,
           mem_data_in
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata, busy, mem_write, mem_read, mem_address,
           mem_data_in
  );
`endif
endinterface

// File: rtl/my_mem_arbiter.sv
// Two-requester round-robin front end for my_mem. One transaction at a time:
// IDLE -> ACCESS -> (WAIT for reads when RD_LAT>1) -> DONE -> IDLE.
// Optional feature macro: MEM_ARB_PARITY_CHK_EN adds a perr pulse flagging a
// read whose bit 8 is not the even parity of bits [7:0].
module my_mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  my_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // WAIT lasts RD_LAT-1 cycles; the counter runs 0 .. RD_LAT-2.
  localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  // Requester granted most recently (1 = req1). Reset to 1 so a tie right
  // after reset goes to req0; it also names the owner of the live txn.
  logic          last_grant;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          any_req;
  logic          pick;
  logic          capture;

  assign any_req = bus.req0 | bus.req1;
  assign bus.busy = (state != IDLE);

  // Winner selection: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) pick = ~last_grant;
  end

  // Read data is sampled on the edge that ends the last cycle mem_read is high.
  always_comb begin
    capture = 1'b0;
    if (state == ACCESS && !we_q && RD_LAT == 1) capture = 1'b1;
    if (state == WAIT && cnt == CNT_LAST)         capture = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (!we_q && RD_LAT > 1) state_nx = WAIT;
               else                     state_nx = DONE;
      WAIT:    if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory pins and acks decoded from state; everything idles low.
  always_comb begin
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_address = '0;
    bus.mem_data_in = '0;
    bus.ack0        = 1'b0;
    bus.ack1        = 1'b0;
    case (state)
      ACCESS: begin
        bus.mem_address = addr_q;
        if (we_q) begin
          bus.mem_write   = 1'b1;
          bus.mem_data_in = wdata_q;
        end else begin
          bus.mem_read    = 1'b1;
        end
      end
      WAIT: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = addr_q;
      end
      DONE: begin
        bus.ack0 = ~last_grant;
        bus.ack1 = last_grant;
      end
      default: ;
    endcase
  end

  // Latch the winner's request and advance the round-robin pointer on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (state == IDLE && any_req) begin
      last_grant <= pick;
      we_q       <= pick ? bus.we1    : bus.we0;
      addr_q     <= pick ? bus.addr1  : bus.addr0;
      wdata_q    <= pick ? bus.wdata1 : bus.wdata0;
    end
  end

  // Read-latency counter, cleared whenever the block is not waiting.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state == WAIT) cnt <= cnt + CW'(1);
    else                    cnt <= '0;
  end

`ifdef MEM_ARB_PARITY_CHK_EN
  // Capture read data; perr is a one-cycle flag that lines up with the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= '0;
      bus.perr  <= 1'b0;
    end else begin
      if (capture) bus.rdata <= bus.mem_data_out;
      bus.perr <= capture & (bus.mem_data_out[8] ^ (^bus.mem_data_out[7:0]));
    end
  end
`else
  // Capture read data; it holds until the next read completes.
  always_ff @(posedge clk) begin
    if (rst)          bus.rdata <= '0;
    else if (capture) bus.rdata <= bus.mem_data_out;
  end
`endif

endmodule
